mips_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the MIPS-style datapath (PC, PC adder, instruction ROM, register file, ALU control, ALU). It replaces free-running single-cycle operation with a FETCH/DECODE/EXEC/WB state machine. It gates PC update and register-file write, latches the instruction register, and decodes R-type funct codes into the 2-bit ALU function. It also detects HALT and illegal instructions.

---
 rtl/mips_seq_pkg.sv | 25 ++
 rtl/mips_seq_decode.sv | 25 ++
 rtl/mips_seq_ctrl.sv | 117 +++++++++++
 tb/tb_mips_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_seq_pkg.sv
// Shared types and constants for the MIPS multi-cycle sequencer.
package mips_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [5:0] R_TYPE_OP = 6'h00;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

endpackage

// File: rtl/mips_seq_decode.sv
// Combinational decode of opcode/funct into the 2-bit ALU function and a legal flag.
module mips_seq_decode
  import mips_seq_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output logic [1:0] o_alu_func,
  output logic       o_legal
);

  always_comb begin
    o_alu_func = ALU_ADD;
    o_legal    = 1'b0;
    if (i_op == R_TYPE_OP) begin
      case (i_funct)
        FUNCT_ADD: begin o_alu_func = ALU_ADD; o_legal = 1'b1; end
        FUNCT_SUB: begin o_alu_func = ALU_SUB; o_legal = 1'b1; end
        FUNCT_AND: begin o_alu_func = ALU_AND; o_legal = 1'b1; end
        FUNCT_OR:  begin o_alu_func = ALU_OR;  o_legal = 1'b1; end
        default:   begin o_alu_func = ALU_ADD; o_legal = 1'b0; end
      endcase
    end
  end

endmodule

// File: rtl/mips_seq_ctrl.sv
// FETCH/DECODE/EXEC/WB sequencer gating PC update and register-file writes.
// Optional breakpoint stop in WB is enabled by defining SEQ_BREAK_EN.
module mips_seq_ctrl
  import mips_seq_pkg::*;
#(
  parameter int unsigned ROM_LAT = 1,
  parameter logic [5:0]  HALT_OP = 6'h3F,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [31:0]      instr,
  output logic             pc_en,
  output logic [31:0]      ir,
  output logic             rf_en,
  output logic             rf_we,
  output logic [1:0]       alu_func,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
`ifdef SEQ_BREAK_EN
  ,
  input  logic             brk_en,
  input  logic             brk_pc_match,
  output logic             brk_hit
`endif
);

  localparam logic [2:0] WAIT_LAST = 3'(ROM_LAT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_wait;
  logic [31:0]      r_ir;
  logic [1:0]       r_alu_func;
  logic [CNT_W-1:0] r_retired;

  logic [5:0] w_dec_op;
  logic [5:0] w_dec_funct;
  logic [1:0] w_dec_alu;
  logic       w_dec_legal;

  // One decoder serves both uses: the incoming word in DECODE (to load
  // alu_func as EXEC begins) and the latched ir in WB (for the legal flag).
  assign w_dec_op    = (r_state == S_DECODE) ? instr[31:26] : r_ir[31:26];
  assign w_dec_funct = (r_state == S_DECODE) ? instr[5:0]   : r_ir[5:0];

  mips_seq_decode u_decode (
    .i_op       (w_dec_op),
    .i_funct    (w_dec_funct),
    .o_alu_func (w_dec_alu),
    .o_legal    (w_dec_legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wait     <= '0;
      r_ir       <= '0;
      r_alu_func <= ALU_ADD;
      r_retired  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && r_wait != WAIT_LAST) r_wait <= r_wait + 3'd1;
      else                                           r_wait <= '0;
      if (r_state == S_DECODE) begin
        r_ir <= instr;
        if (instr[31:26] != HALT_OP) r_alu_func <= w_dec_alu;
      end
      if (r_state == S_WB) r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    w_next  = r_state;
    pc_en   = 1'b0;
    rf_en   = 1'b0;
    rf_we   = 1'b0;
    illegal = 1'b0;
`ifdef SEQ_BREAK_EN
    brk_hit = 1'b0;
`endif
    unique case (r_state)
      S_IDLE:   if (run) w_next = S_FETCH;
      S_FETCH:  if (r_wait == WAIT_LAST) w_next = S_DECODE;
      S_DECODE: w_next = (instr[31:26] == HALT_OP) ? S_HALT : S_EXEC;
      S_EXEC: begin
        rf_en  = 1'b1;
        w_next = S_WB;
      end
      S_WB: begin
        rf_en   = 1'b1;
        pc_en   = 1'b1;
        rf_we   = w_dec_legal;
        illegal = ~w_dec_legal;
        w_next  = run ? S_FETCH : S_IDLE;
`ifdef SEQ_BREAK_EN
        if (brk_en && brk_pc_match) begin
          w_next  = S_IDLE;
          brk_hit = 1'b1;
        end
`endif
      end
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IDLE;
    endcase
  end

  assign ir       = r_ir;
  assign alu_func = r_alu_func;
  assign retired  = r_retired;
  assign busy     = (r_state != S_IDLE) && (r_state != S_HALT);
  assign halted   = (r_state == S_HALT);

endmodule

// File: tb/tb_mips_seq_ctrl.sv
// Directed-plus-random bench for mips_seq_ctrl using a transaction-level reference model.
module tb_mips_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run_a = 1'b0;
  logic        run_b = 1'b0;
  logic [31:0] instr = '0;

  logic        a_pc_en, a_rf_en, a_rf_we, a_busy, a_halted, a_illegal;
  logic [31:0] a_ir;
  logic [1:0]  a_alu;
  logic [15:0] a_ret;
  logic        b_pc_en, b_rf_en, b_rf_we, b_busy, b_halted, b_illegal;
  logic [31:0] b_ir;
  logic [1:0]  b_alu;
  logic [2:0]  b_ret;

  always #5 clk = ~clk;

  mips_seq_ctrl #(.ROM_LAT(1), .HALT_OP(6'h3F), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .run(run_a), .instr(instr),
    .pc_en(a_pc_en), .ir(a_ir), .rf_en(a_rf_en), .rf_we(a_rf_we),
    .alu_func(a_alu), .busy(a_busy), .halted(a_halted),
    .illegal(a_illegal), .retired(a_ret)
  );

  mips_seq_ctrl #(.ROM_LAT(3), .HALT_OP(6'h3F), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .run(run_b), .instr(instr),
    .pc_en(b_pc_en), .ir(b_ir), .rf_en(b_rf_en), .rf_we(b_rf_we),
    .alu_func(b_alu), .busy(b_busy), .halted(b_halted),
    .illegal(b_illegal), .retired(b_ret)
  );

  int sel = 0;
  logic        o_pc_en, o_rf_en, o_rf_we, o_busy, o_halted, o_illegal;
  logic [31:0] o_ir, o_ret;
  logic [1:0]  o_alu;

  always_comb begin
    if (sel == 0) begin
      o_pc_en = a_pc_en; o_rf_en = a_rf_en; o_rf_we = a_rf_we; o_busy = a_busy;
      o_halted = a_halted; o_illegal = a_illegal; o_ir = a_ir; o_alu = a_alu;
      o_ret = 32'(a_ret);
    end else begin
      o_pc_en = b_pc_en; o_rf_en = b_rf_en; o_rf_we = b_rf_we; o_busy = b_busy;
      o_halted = b_halted; o_illegal = b_illegal; o_ir = b_ir; o_alu = b_alu;
      o_ret = 32'(b_ret);
    end
  end

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned m_ret [2];
  logic [1:0]  m_alu [2];
  int unsigned lat   [2];
  int unsigned cmod  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic ref_decode(input logic [31:0] ins, output logic legal, output logic [1:0] alu);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    legal = 1'b0;
    alu   = 2'b00;
    if (op == 6'd0) begin
      if (fn == 6'h20) begin legal = 1'b1; alu = 2'b00; end
      if (fn == 6'h22) begin legal = 1'b1; alu = 2'b01; end
      if (fn == 6'h24) begin legal = 1'b1; alu = 2'b10; end
      if (fn == 6'h25) begin legal = 1'b1; alu = 2'b11; end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0]  fn_tab [4];
    logic [31:0] w;
    int unsigned r;
    fn_tab[0] = 6'h20; fn_tab[1] = 6'h22; fn_tab[2] = 6'h24; fn_tab[3] = 6'h25;
    w = $urandom();
    r = $urandom_range(0, 9);
    if (r < 7) begin
      w[31:26] = 6'd0;
      w[5:0]   = fn_tab[$urandom_range(0, 3)];
    end else if (r == 7) begin
      w[31:26] = 6'd0;
    end else begin
      w[31:26] = 6'($urandom_range(1, 62));
    end
    return w;
  endfunction

  task automatic set_run(input int s, input logic v);
    if (s == 0) run_a = v; else run_b = v;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"},   32'(o_busy),    32'd0);
    chk({tag, "_halted"}, 32'(o_halted),  32'd0);
    chk({tag, "_pc_en"},  32'(o_pc_en),   32'd0);
    chk({tag, "_rf_en"},  32'(o_rf_en),   32'd0);
    chk({tag, "_rf_we"},  32'(o_rf_we),   32'd0);
    chk({tag, "_illegal"},32'(o_illegal), 32'd0);
    chk({tag, "_retired"},o_ret,          32'(m_ret[sel]));
    chk({tag, "_alu"},    32'(o_alu),     32'(m_alu[sel]));
  endtask

  // One full instruction: ROM_LAT fetch cycles, then DECODE, EXEC, WB.
  task automatic do_instr(input int s, input logic [31:0] ins, input logic keep_run,
                          input logic drop_in_fetch);
    logic       legal;
    logic [1:0] alu;
    int unsigned n;
    n = lat[s];
    ref_decode(ins, legal, alu);
    instr = ins;
    for (int unsigned k = 0; k < n + 3; k++) begin
      @(posedge clk); #1;
      chk("busy",    32'(o_busy),    32'd1);
      chk("halted",  32'(o_halted),  32'd0);
      chk("pc_en",   32'(o_pc_en),   32'(k == n + 2));
      chk("rf_en",   32'(o_rf_en),   32'(k >= n + 1));
      chk("rf_we",   32'(o_rf_we),   32'((k == n + 2) && legal));
      chk("illegal", 32'(o_illegal), 32'((k == n + 2) && !legal));
      chk("retired", o_ret,          32'(m_ret[s]));
      if (k >= n + 1) begin
        chk("alu_func", 32'(o_alu), 32'(alu));
        chk("ir",       o_ir,       ins);
      end else begin
        chk("alu_hold", 32'(o_alu), 32'(m_alu[s]));
      end
      if (k == 0 && drop_in_fetch) set_run(s, 1'b0);
      if (k == n + 2) set_run(s, keep_run);
    end
    m_alu[s] = alu;
    m_ret[s] = (m_ret[s] + 1) % cmod[s];
  endtask

  task automatic do_halt(input int s);
    instr = 32'hFC00_0000;
    for (int unsigned k = 0; k <= lat[s]; k++) begin
      @(posedge clk); #1;
      chk("halt_pre_busy",  32'(o_busy),   32'd1);
      chk("halt_pre_pc_en", 32'(o_pc_en),  32'd0);
      chk("halt_pre_halt",  32'(o_halted), 32'd0);
    end
    for (int unsigned j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      chk("halt_halted",  32'(o_halted), 32'd1);
      chk("halt_busy",    32'(o_busy),   32'd0);
      chk("halt_pc_en",   32'(o_pc_en),  32'd0);
      chk("halt_rf_we",   32'(o_rf_we),  32'd0);
      chk("halt_retired", o_ret,         32'(m_ret[s]));
      chk("halt_alu",     32'(o_alu),    32'(m_alu[s]));
    end
    rst = 1'b1; #1;
    for (int i = 0; i < 2; i++) begin m_ret[i] = 0; m_alu[i] = 2'b00; end
    chk("halt_rst_halted", 32'(o_halted), 32'd0);
    chk("halt_rst_busy",   32'(o_busy),   32'd0);
    chk("halt_rst_ret",    o_ret,         32'd0);
    chk("halt_rst_ir",     o_ir,          32'd0);
    set_run(s, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle("halt_after_rst");
  endtask

  initial begin
    lat[0] = 1; lat[1] = 3;
    cmod[0] = 65536; cmod[1] = 8;
    for (int i = 0; i < 2; i++) begin m_ret[i] = 0; m_alu[i] = 2'b00; end

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    sel = 0; #0; check_idle("rst_a");
    chk("rst_ir_a", o_ir, 32'd0);
    sel = 1; #0; check_idle("rst_b");
    rst = 1'b0;
    sel = 0;

    // Reset asserted mid-EXEC aborts the instruction without strobes
    instr = 32'h0022_1820;
    run_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midexec_rf_en", 32'(o_rf_en), 32'd1);
    #2 rst = 1'b1; #1;
    chk("midrst_busy",  32'(o_busy),  32'd0);
    chk("midrst_pc_en", 32'(o_pc_en), 32'd0);
    chk("midrst_rf_we", 32'(o_rf_we), 32'd0);
    chk("midrst_ret",   o_ret,        32'd0);
    run_a = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle("midrst_after");

    // Back-to-back directed R-type and illegal, then random, on ROM_LAT=1
    run_a = 1'b1;
    do_instr(0, 32'h0022_1820, 1'b1, 1'b0);
    do_instr(0, 32'h0022_1822, 1'b1, 1'b0);
    do_instr(0, 32'h0022_1824, 1'b1, 1'b0);
    do_instr(0, 32'h0022_1825, 1'b1, 1'b0);
    do_instr(0, 32'h0000_003F, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) do_instr(0, rand_instr(), 1'b1, 1'b0);
    do_instr(0, 32'h0443_0020, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_idle("a_stop");

    // HALT is absorbing even with run held high
    run_a = 1'b1;
    do_halt(0);

    // ROM_LAT=3: run dropped during FETCH still completes, then idles
    sel = 1;
    run_b = 1'b1;
    do_instr(1, 32'h0022_1822, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_idle("b_drop");

    // Counter wrap on a 3-bit retired count
    run_b = 1'b1;
    for (int i = 0; i < 9; i++) do_instr(1, rand_instr(), 1'b1, 1'b0);
    do_instr(1, 32'h0000_0025, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_idle("b_wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
